wb_queue: RTL

- Writeback stage directly downstream of the ALU/MEM/IO execution unit.
- Accepts up to three results per cycle (MEM, IO, ALU channels, each an addr/val pair; addr 0 = no result) into a shared in-order queue.
- Drains one result per cycle to the single register-file write port.
- Provides a forwarding lookup for the issue stage and a stall signal so the queue never has to drop results.

---
 rtl/wb_queue_pkg.sv | 11 +
 rtl/wb_queue.sv | 109 ++++++++++
 2 files changed

// File: rtl/wb_queue_pkg.sv
// wb_queue_pkg: shared register/data widths and writeback channel ordering
package wb_queue_pkg;
  localparam int REG_AW = 6;
  localparam int DATA_W = 32;
  localparam logic [REG_AW-1:0] REG_NONE = 6'd0;
  localparam int NCH = 3;
  typedef enum logic [1:0] {CH_MEM = 2'd0, CH_IO = 2'd1, CH_ALU = 2'd2} ch_e;
  // Enqueue priority, oldest-issued first: MEM (4-cycle pipe), then IO, then ALU.
  // The issue-stage scoreboard relies on this same order to pick the final value.
  localparam ch_e CH_ORDER [NCH] = '{CH_MEM, CH_IO, CH_ALU};
endpackage

// File: rtl/wb_queue.sv
// wb_queue: in-order writeback queue, 3 results in / 1 register-file write out, with forwarding
module wb_queue
  import wb_queue_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int STALL_LEVEL = 8,
  parameter int AW = REG_AW,
  parameter int DW = DATA_W
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_dd_val,
  input  logic [AW-1:0] io_addr,
  input  logic [DW-1:0] io_dd_val,
  input  logic [AW-1:0] alu_addr,
  input  logic [DW-1:0] alu_dd_val,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_val,
  input  logic [AW-1:0] fwd_addr,
  output logic          fwd_hit,
  output logic [DW-1:0] fwd_val,
  output logic          wb_stall,
  output logic          wb_empty,
  output logic          ovf
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] val_q [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count, free, enq;
  logic [AW-1:0] src_addr [NCH];
  logic [DW-1:0] src_val [NCH];
  logic [AW-1:0] ch_addr [NCH];
  logic [DW-1:0] ch_val [NCH];
  logic [PW-1:0] slot [NCH];
  logic [NCH-1:0] acc;
  logic deq, drop;
  assign deq = count != '0;
  assign free = CW'(DEPTH) - count + CW'(deq);
  assign wb_stall = count >= CW'(STALL_LEVEL);
  assign wb_empty = count == '0 && !wr_en;
  // Accept valid channels in priority order into consecutive tail slots until free space runs out
  always_comb begin
    src_addr[CH_MEM] = mem_addr;
    src_val[CH_MEM] = mem_dd_val;
    src_addr[CH_IO] = io_addr;
    src_val[CH_IO] = io_dd_val;
    src_addr[CH_ALU] = alu_addr;
    src_val[CH_ALU] = alu_dd_val;
    enq = '0;
    drop = 1'b0;
    acc = '0;
    for (int i = 0; i < NCH; i++) begin
      ch_addr[i] = src_addr[CH_ORDER[i]];
      ch_val[i] = src_val[CH_ORDER[i]];
      slot[i] = tail + enq[PW-1:0];
      if (ch_addr[i] != AW'(REG_NONE)) begin
        acc[i] = enq < free;
        drop = drop | (enq >= free);
        enq = enq + CW'(enq < free);
      end
    end
  end
  // Entry storage: written only for accepted channels, never reset
  always_ff @(posedge clk)
    for (int i = 0; i < NCH; i++)
      if (acc[i]) begin
        addr_q[slot[i]] <= ch_addr[i];
        val_q[slot[i]] <= ch_val[i];
      end
  // Pointers, occupancy, registered write port and sticky overflow
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_val <= '0;
      ovf <= 1'b0;
    end else begin
      tail <= tail + enq[PW-1:0];
      head <= head + PW'(deq);
      count <= count + enq - CW'(deq);
      wr_en <= deq;
      if (deq) begin
        wr_addr <= addr_q[head];
        wr_val <= val_q[head];
      end
      if (drop) ovf <= 1'b1;
    end
  // Forwarding: youngest queued match wins (scan oldest-to-youngest, last hit overrides), else the in-flight write
  always_comb begin
    fwd_hit = 1'b0;
    fwd_val = '0;
    for (int k = DEPTH - 1; k >= 0; k--)
      if (fwd_addr != AW'(REG_NONE) && CW'(k) < count && addr_q[tail - PW'(k + 1)] == fwd_addr) begin
        fwd_hit = 1'b1;
        fwd_val = val_q[tail - PW'(k + 1)];
      end
    if (!fwd_hit && fwd_addr != AW'(REG_NONE) && wr_en && wr_addr == fwd_addr) begin
      fwd_hit = 1'b1;
      fwd_val = wr_val;
    end
  end
endmodule
